// File: rtl/alu_result_queue.sv
// alu_result_queue: FIFO of ALU results/flags, serialised onto a tri-state bus least-significant slice first
module alu_result_queue #(
  parameter int BUS_W = 8,
  parameter int RESULT_W = 16,
  parameter int FLAG_W = 3,
  parameter int DEPTH = 4,
  parameter int AUTO_DRAIN = 0,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic [RESULT_W-1:0] alu_result_i,
  input  logic [FLAG_W-1:0]   flags_i,
  input  logic                grab_i,
  input  logic                drain_i,
  input  logic                bus_ready_i,
  input  logic                clear_ovf_i,
  output logic [BUS_W-1:0]    bus_out_o,
  output logic                bus_oe_o,
  output logic [FLAG_W-1:0]   flags_out_o,
  output logic                done_o,
  output logic                busy_o,
  output logic [CW-1:0]       count_o,
  output logic                full_o,
  output logic                empty_o,
  output logic                overflow_o
);
  localparam int NS = RESULT_W / BUS_W;
  localparam int KW = NS > 1 ? $clog2(NS) : 1;
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int EW = FLAG_W + RESULT_W;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q, state_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] head;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic [KW-1:0] k_q, k_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic done_q, done_d, ovf_q, ovf_d, push, pop, start;
  assign head = mem_q[rd_q];
  assign full_o = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
  assign pop = state_q == SEND && bus_ready_i && k_q == KW'(NS - 1);
  // a full FIFO still accepts a grab when the head leaves at the same edge
  assign push = grab_i && (!full_o || pop);
  assign start = state_q == IDLE && !empty_o && (drain_i || AUTO_DRAIN != 0);
  always_comb begin
    state_d = start ? SEND : pop ? IDLE : state_q;
    k_d = state_q == IDLE || pop ? '0 : bus_ready_i ? k_q + 1'b1 : k_q;
    rd_d = pop ? (rd_q == PW'(DEPTH - 1) ? '0 : rd_q + 1'b1) : rd_q;
    wr_d = push ? (wr_q == PW'(DEPTH - 1) ? '0 : wr_q + 1'b1) : wr_q;
    count_d = count_q + CW'(push) - CW'(pop);
    flags_d = pop ? head[RESULT_W +: FLAG_W] : flags_q;
    done_d = pop;
    ovf_d = (grab_i && full_o && !pop) || (ovf_q && !clear_ovf_i);
  end
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      k_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
      flags_q <= '0;
      done_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      count_q <= count_d;
      flags_q <= flags_d;
      done_q <= done_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge clock_i) begin
    if (push) mem_q[wr_q] <= {flags_i, alu_result_i};
  end
  assign busy_o = state_q == SEND;
  assign bus_oe_o = busy_o;
  assign bus_out_o = bus_oe_o ? head[k_q * BUS_W +: BUS_W] : 'z;
  assign count_o = count_q;
  assign flags_out_o = flags_q;
  assign done_o = done_q;
  assign overflow_o = ovf_q;
endmodule

// File: tb/tb_alu_result_queue.sv
// tb_alu_result_queue: directed and random stimulus for manual- and auto-drain instances,
// checked every cycle against a queue-based reference model
module tb_alu_result_queue;
  logic clk = 0, rst = 1, grab = 0, drain = 0, rdy = 0, clr = 0;
  logic [15:0] res = 0;
  logic [2:0] flg = 0;
  wire [7:0] bo_a, bo_b;
  logic oe_a, oe_b, dn_a, dn_b, by_a, by_b, fu_a, fu_b, em_a, em_b, ov_a, ov_b;
  logic [2:0] fo_a, fo_b, cn_a, cn_b;
  int total = 0, bad = 0;
  bit sel = 0, auto_m = 0;
  logic [18:0] q [$];
  bit snd = 0, ovf = 0, dn = 0;
  int k = 0;
  logic [2:0] fo = 0;

  always #5 clk = ~clk;

  alu_result_queue #(.AUTO_DRAIN(0)) ua (
    .clock_i(clk), .reset_i(rst), .alu_result_i(res), .flags_i(flg), .grab_i(grab),
    .drain_i(drain), .bus_ready_i(rdy), .clear_ovf_i(clr), .bus_out_o(bo_a), .bus_oe_o(oe_a),
    .flags_out_o(fo_a), .done_o(dn_a), .busy_o(by_a), .count_o(cn_a), .full_o(fu_a),
    .empty_o(em_a), .overflow_o(ov_a));

  alu_result_queue #(.AUTO_DRAIN(1)) ub (
    .clock_i(clk), .reset_i(rst), .alu_result_i(res), .flags_i(flg), .grab_i(grab),
    .drain_i(drain), .bus_ready_i(rdy), .clear_ovf_i(clr), .bus_out_o(bo_b), .bus_oe_o(oe_b),
    .flags_out_o(fo_b), .done_o(dn_b), .busy_o(by_b), .count_o(cn_b), .full_o(fu_b),
    .empty_o(em_b), .overflow_o(ov_b));

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, o, e);
    end
  endtask

  task automatic mclear();
    q.delete();
    snd = 0; k = 0; ovf = 0; fo = 0; dn = 0;
  endtask

  // one clock edge of the reference behaviour, from the inputs present at that edge
  task automatic mstep();
    bit pop, full0, snd0;
    int n0;
    n0 = q.size();
    full0 = n0 == 4;
    snd0 = snd;
    pop = snd && rdy && k == 1;
    dn = pop;
    if (pop) begin
      fo = q[0][18:16];
      void'(q.pop_front());
      snd = 0;
    end else if (snd && rdy) k++;
    if (!snd0 && n0 > 0 && (drain || auto_m)) begin
      snd = 1;
      k = 0;
    end
    if (grab && (!full0 || pop)) q.push_back({flg, res});
    ovf = (grab && full0 && !pop) || (ovf && !clr);
  endtask

  task automatic check_all();
    logic [18:0] h;
    h = q.size() > 0 ? q[0] : '0;
    chk("bus_oe", sel ? oe_b : oe_a, snd);
    chk("busy", sel ? by_b : by_a, snd);
    if (snd) chk("bus_out", sel ? bo_b : bo_a, h[k*8 +: 8]);
    chk("count", sel ? cn_b : cn_a, q.size());
    chk("full", sel ? fu_b : fu_a, q.size() == 4);
    chk("empty", sel ? em_b : em_a, q.size() == 0);
    chk("overflow", sel ? ov_b : ov_a, ovf);
    chk("flags_out", sel ? fo_b : fo_a, fo);
    chk("done", sel ? dn_b : dn_a, dn);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) mclear(); else mstep();
    #1;
    check_all();
  endtask

  task automatic put(input logic [15:0] r, input logic [2:0] f);
    grab = 1; res = r; flg = f;
    step();
    grab = 0;
  endtask

  task automatic drain_one();
    drain = 1;
    step();
    drain = 0;
    rdy = 1;
    step();
    step();
    rdy = 0;
  endtask

  task automatic do_reset();
    rst = 1; grab = 0; drain = 0; rdy = 0; clr = 0;
    step();
    rst = 0;
    step();
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      grab = 1'($urandom_range(0, 1));
      res = 16'($urandom);
      flg = 3'($urandom);
      drain = $urandom_range(0, 2) == 0;
      rdy = 1'($urandom_range(0, 1));
      clr = $urandom_range(0, 7) == 0;
      step();
    end
    grab = 0; drain = 0; rdy = 0; clr = 0;
  endtask

  initial begin
    do_reset();
    chk("reset_count", cn_a, 0);
    chk("reset_oe", oe_a, 0);
    put(16'hA55A, 3'b101);
    drain = 1;
    step();
    drain = 0;
    chk("t2_slice0", bo_a, 8'h5A);
    rdy = 1;
    step();
    chk("t2_slice1", bo_a, 8'hA5);
    step();
    chk("t2_flags", fo_a, 3'b101);
    rdy = 0;
    step();
    put(16'hA55A, 3'b101);
    drain = 1;
    step();
    drain = 0;
    repeat (3) step();
    chk("t3_hold", bo_a, 8'h5A);
    rdy = 1;
    repeat (3) step();
    rdy = 0;
    put(16'h1111, 1); put(16'h2222, 2); put(16'h3333, 3); put(16'h4444, 4); put(16'h5555, 5);
    chk("t4_full", fu_a, 1);
    chk("t4_ovf", ov_a, 1);
    repeat (4) drain_one();
    clr = 1;
    step();
    clr = 0;
    chk("t4_clr", ov_a, 0);
    put(16'h0A0A, 1); put(16'h0B0B, 2); put(16'h0C0C, 3); put(16'h0D0D, 4);
    drain = 1;
    step();
    drain = 0;
    rdy = 1;
    step();
    grab = 1; res = 16'hBEEF; flg = 3'b110;
    step();
    grab = 0; rdy = 0;
    chk("t5_count", cn_a, 4);
    chk("t5_ovf", ov_a, 0);
    repeat (4) drain_one();
    drain = 1;
    step();
    drain = 0;
    random_run(300);
    sel = 1;
    auto_m = 1;
    do_reset();
    put(16'h1234, 1); put(16'h5678, 2); put(16'h9ABC, 3);
    rdy = 1;
    repeat (12) step();
    rdy = 0;
    put(16'hCAFE, 6);
    step();
    chk("t6_busy", by_b, 1);
    #2;
    rst = 1;
    #1;
    chk("t6_async_oe", oe_b, 0);
    chk("t6_async_count", cn_b, 0);
    mclear();
    step();
    rst = 0;
    step();
    random_run(300);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
